// File: rtl/mensaje_uart_tx.sv
// rtl/mensaje_uart_tx.sv - 8N1 UART transmitter for a fixed-length ASCII message
module mensaje_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int NUM_BYTES    = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enviar,
  input  logic [8*NUM_BYTES-1:0] mensaje,
  output logic                   tx,
  output logic                   ocupado,
  output logic                   listo
);

  localparam int MSG_W  = 8 * NUM_BYTES;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [7:0]        shift;
  logic [MSG_W-1:0]  hold;
  logic [MSG_W-1:0]  hold_next;
  logic              bit_end;

  // The holding register is consumed from the top: after each byte it moves
  // up by one byte so the next byte to send always sits in the top 8 bits.
  assign hold_next = hold << 8;
  assign bit_end   = (clk_cnt == CNT_LAST);

  // Frame sequencer: bit timing, byte stepping and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      hold     <= '0;
      tx       <= 1'b1;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
    end else begin
      listo <= 1'b0;

      // Bit timer only runs while a frame is on the line; it ends at zero
      // after the final stop bit, so it is ready for the next message.
      if (state != IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enviar) begin
            hold     <= mensaje;
            shift    <= mensaje[MSG_W-1 -: 8];
            byte_cnt <= '0;
            clk_cnt  <= '0;
            ocupado  <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Drive the next bit directly so tx stays registered without
              // waiting a cycle for the shifted value.
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (byte_cnt == BYTE_LAST) begin
              ocupado <= 1'b0;
              listo   <= 1'b1;
              state   <= IDLE;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_cnt <= byte_cnt + 1'b1;
              hold     <= hold_next;
              shift    <= hold_next[MSG_W-1 -: 8];
              tx       <= 1'b0;
              state    <= START;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mensaje_uart_tx.sv
// tb/tb_mensaje_uart_tx.sv - randomized self-checking bench for mensaje_uart_tx
module tb_mensaje_uart_tx;

  localparam int NB    = 6;
  localparam int CPB_A = 4;
  localparam int CPB_B = 434;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        enviar  = 1'b0;
  logic        sel     = 1'b0;
  logic [47:0] mensaje = '0;

  logic enviar_a, enviar_b;
  logic tx_a, ocupado_a, listo_a;
  logic tx_b, ocupado_b, listo_b;
  logic tx_s, ocupado_s, listo_s;

  int n_tests = 0;
  int n_fail  = 0;

  assign enviar_a  = enviar & ~sel;
  assign enviar_b  = enviar & sel;
  assign tx_s      = sel ? tx_b : tx_a;
  assign ocupado_s = sel ? ocupado_b : ocupado_a;
  assign listo_s   = sel ? listo_b : listo_a;

  mensaje_uart_tx #(.CLK_FREQ(16), .BAUD(4)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .enviar  (enviar_a),
    .mensaje (mensaje),
    .tx      (tx_a),
    .ocupado (ocupado_a),
    .listo   (listo_a)
  );

  mensaje_uart_tx dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .enviar  (enviar_b),
    .mensaje (mensaje),
    .tx      (tx_b),
    .ocupado (ocupado_b),
    .listo   (listo_b)
  );

  // free-running system clock
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] msg_byte(input logic [47:0] m, input int k);
    return 8'(m >> (8 * (NB - 1 - k)));
  endfunction

  // Line level of serial bit b of a message: each byte is start, 8 data LSB first, stop.
  function automatic int line_bit(input logic [47:0] m, input int b);
    logic [7:0] by;
    int pos;
    by  = msg_byte(m, b / 10);
    pos = b % 10;
    if (pos == 0) return 0;
    if (pos == 9) return 1;
    return int'(by[pos-1]);
  endfunction

  task automatic start_msg(input logic [47:0] m);
    @(negedge clock);
    mensaje = m;
    enviar  = 1'b1;
    @(posedge clock);
  endtask

  // Called just after the edge that sampled enviar; checks the whole message.
  task automatic watch_msg(input logic [47:0] m, input int cpb, input int poke_at,
                           input logic [47:0] poke_msg, input bit chain,
                           input logic [47:0] chain_msg);
    int first, consistent, busy_cnt, early, expv, b, off;
    logic [7:0] dec;
    first = 0; consistent = 1; busy_cnt = 0; early = 0; dec = '0;
    for (int c = 1; c <= 10 * NB * cpb; c++) begin
      @(negedge clock);
      enviar = (c == poke_at);
      if (c == poke_at) mensaje = poke_msg;
      b    = (c - 1) / cpb;
      off  = (c - 1) % cpb;
      expv = line_bit(m, b);
      if (off == 0) begin
        first      = int'(tx_s);
        consistent = 1;
      end else if (int'(tx_s) != first) begin
        consistent = 0;
      end
      if (off == cpb / 2 && b % 10 >= 1 && b % 10 <= 8) dec[b % 10 - 1] = tx_s;
      if (ocupado_s) busy_cnt++;
      if (listo_s) early++;
      if (off == cpb - 1) begin
        check_eq("bit", consistent ? first : 2, expv);
        if (b % 10 == 9) check_eq("byte", dec, msg_byte(m, b / 10));
      end
    end
    @(negedge clock);
    check_eq("listo", listo_s, 1);
    check_eq("ocupado_end", ocupado_s, 0);
    check_eq("ocupado_cycles", busy_cnt, 10 * NB * cpb);
    check_eq("listo_early", early, 0);
    if (chain) begin
      enviar  = 1'b1;
      mensaje = chain_msg;
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      enviar = 1'b0;
      if (tx_s !== 1'b1 || listo_s !== 1'b0 || ocupado_s !== 1'b0) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  function automatic logic [47:0] rand_msg();
    return {16'($urandom), 32'($urandom)};
  endfunction

  initial begin
    logic [47:0] m1, m2, m3, m4, m5, m6;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_tx_a", tx_a, 1);
    check_eq("rst_ocupado_a", ocupado_a, 0);
    check_eq("rst_listo_a", listo_a, 0);
    check_eq("rst_tx_b", tx_b, 1);
    check_eq("rst_ocupado_b", ocupado_b, 0);
    reset_n = 1'b1;
    idle_check(5, "idle_after_reset");

    // single message from the composer
    start_msg(48'h23_31_32_33_34_0A);
    watch_msg(48'h23_31_32_33_34_0A, CPB_A, 0, '0, 1'b0, '0);
    idle_check(20, "idle_after_single");

    // request and message change while busy are ignored
    m1 = rand_msg();
    start_msg(m1);
    watch_msg(m1, CPB_A, 50, 48'h21_39_39_39_39_0D, 1'b0, '0);
    idle_check(300, "no_second_listo");

    // back-to-back: new request in the listo cycle
    m2 = rand_msg();
    m3 = rand_msg();
    start_msg(m2);
    watch_msg(m2, CPB_A, 0, '0, 1'b1, m3);
    @(posedge clock);
    watch_msg(m3, CPB_A, 0, '0, 1'b0, '0);
    idle_check(20, "idle_after_b2b");

    // asynchronous reset mid-frame
    m4 = rand_msg();
    start_msg(m4);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      enviar = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_tx", tx_a, 1);
    check_eq("abort_ocupado", ocupado_a, 0);
    check_eq("abort_listo", listo_a, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle_check(300, "no_listo_after_abort");
    m5 = rand_msg();
    start_msg(m5);
    watch_msg(m5, CPB_A, 0, '0, 1'b0, '0);

    // default rate instance
    sel = 1'b1;
    m6  = {rand_msg()} << 8 | 48'h0A;
    idle_check(20, "idle_before_default");
    start_msg(m6);
    watch_msg(m6, CPB_B, 0, '0, 1'b0, '0);
    idle_check(20, "idle_after_default");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
